// File: rtl/instr_fetch.sv
`default_nettype none
// instr_fetch: PC register feeding instruction memory plus a 2-entry {pc, instr} buffer toward decode.
// Optional halt-on-16'hFFFF detection is compiled in with macro INSTR_FETCH_HALT_DETECT_EN.
module instr_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [7:0]  pc_out,
    input  logic [15:0] instr_in,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [7:0]  out_pc,
    output logic        halted
);

    logic [7:0]  r_pc;
    logic [1:0]  r_count;
    logic [7:0]  r_pc0;
    logic [15:0] r_instr0;
    logic [7:0]  r_pc1;
    logic [15:0] r_instr1;

    logic        w_halted;
    logic        w_transfer;
    logic        w_fetch_en;

`ifdef INSTR_FETCH_HALT_DETECT_EN
    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

    state_t r_state;

    assign w_halted = (r_state == ST_HALT);
`else
    assign w_halted = 1'b0;
`endif

    assign w_transfer = (r_count != 2'd0) && out_ready;
    assign w_fetch_en = !redirect_valid && !w_halted && ((r_count != 2'd2) || w_transfer);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_count  <= 2'd0;
            r_pc0    <= 8'h00;
            r_instr0 <= 16'h0000;
            r_pc1    <= 8'h00;
            r_instr1 <= 16'h0000;
`ifdef INSTR_FETCH_HALT_DETECT_EN
            r_state  <= ST_FETCH;
`endif
        end else if (redirect_valid) begin
            // Redirect flushes the buffer; a concurrent transfer is still considered consumed.
            r_pc     <= redirect_pc;
            r_count  <= 2'd0;
`ifdef INSTR_FETCH_HALT_DETECT_EN
            r_state  <= ST_FETCH;
`endif
        end else begin
            if (w_fetch_en) begin
                r_pc <= r_pc + 8'd1;
`ifdef INSTR_FETCH_HALT_DETECT_EN
                if (instr_in == 16'hFFFF) begin
                    r_state <= ST_HALT;
                end
`endif
            end

            // Entry 0 is always the head; a pop shifts entry 1 down.
            case ({w_fetch_en, w_transfer})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_pc0    <= r_pc;
                        r_instr0 <= instr_in;
                    end else begin
                        r_pc1    <= r_pc;
                        r_instr1 <= instr_in;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_pc0    <= r_pc1;
                    r_instr0 <= r_instr1;
                    r_count  <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_pc0    <= r_pc;
                        r_instr0 <= instr_in;
                    end else begin
                        r_pc0    <= r_pc1;
                        r_instr0 <= r_instr1;
                        r_pc1    <= r_pc;
                        r_instr1 <= instr_in;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pc_out    = r_pc;
    assign out_valid = (r_count != 2'd0);
    assign out_instr = r_instr0;
    assign out_pc    = r_pc0;
    assign halted    = w_halted;

endmodule
`default_nettype wire
